// File: rtl/bcd_pkg.sv
// Shared BCD definitions for the BCD counter family (incrementer and
// down-counter).
//   bcd_digit_t   : one packed BCD digit
//   BCD_ZERO/NINE : digit bounds used by borrow/carry and wrap logic
//   is_bcd_digit  : true when a nibble holds a legal decimal digit (0-9)
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_ZERO = 4'd0;
  localparam bcd_digit_t BCD_NINE = 4'd9;

  function automatic logic is_bcd_digit(input bcd_digit_t d);
    return (d <= BCD_NINE);
  endfunction

endpackage

// File: rtl/bcd_dec_digit.sv
// Combinational single-digit BCD decrement with ripple borrow.
//   digit      : current BCD digit
//   borrow_in  : request to take one from this digit
//   digit_out  : digit after the borrow is applied
//   borrow_out : borrow passed to the next more-significant digit
module bcd_dec_digit
  import bcd_pkg::*;
(
  input  bcd_digit_t digit,
  input  logic       borrow_in,
  output bcd_digit_t digit_out,
  output logic       borrow_out
);

  always_comb begin
    digit_out  = digit;
    borrow_out = 1'b0;
    if (borrow_in) begin
      if (digit == BCD_ZERO) begin
        digit_out  = BCD_NINE;
        borrow_out = 1'b1;
      end else begin
        digit_out  = digit - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_down_counter.sv
// Multi-digit packed BCD down-counter (countdown timer core).
//   clk, reset : system clock, asynchronous active-high reset
//   load       : load request, takes load_val on the next edge (wins over dec)
//   load_val   : packed BCD load value, digit 0 in bits [3:0]
//   dec        : decrement tick, one BCD step per cycle it is high
//   count      : registered packed BCD count
//   zero       : registered, high while count is all zeros
//   done       : one-cycle pulse when a dec takes count from 1 to 0
//   wrapped    : one-cycle pulse when a dec at zero wraps to all nines (WRAP=1)
//   load_err   : one-cycle pulse when a load carries a digit above 9
//
// Implicit two-state behaviour, encoded by zero_q:
//   state      | meaning
//   COUNTING   | zero_q = 0, count nonzero, dec steps down
//   IDLE_ZERO  | zero_q = 1, dec saturates (WRAP=0) or wraps to all nines
module bcd_down_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter bit WRAP   = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic                dec,
  output logic [4*DIGITS-1:0] count,
  output logic                zero,
  output logic                done,
  output logic                wrapped,
  output logic                load_err
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0]    count_q, count_d;
  logic            zero_q, zero_d;
  logic            done_q, done_d;
  logic            wrapped_q, wrapped_d;
  logic            load_err_q, load_err_d;

  logic [W-1:0]    count_dec;
  logic [DIGITS:0] borrow;
  logic            at_zero;
  logic            load_ok;

  // Digit 0 always receives the borrow; the borrow leaving the top digit
  // means every digit was zero, and the chain output is then all nines,
  // which is exactly the wrap value.
  assign borrow[0] = 1'b1;
  assign at_zero   = borrow[DIGITS];

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_dec_digit u_dec_digit (
      .digit      (count_q[4*g +: 4]),
      .borrow_in  (borrow[g]),
      .digit_out  (count_dec[4*g +: 4]),
      .borrow_out (borrow[g+1])
    );
  end

  always_comb begin
    load_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!is_bcd_digit(load_val[4*i +: 4])) load_ok = 1'b0;
    end
  end

  always_comb begin
    count_d    = count_q;
    done_d     = 1'b0;
    wrapped_d  = 1'b0;
    load_err_d = 1'b0;
    if (load) begin
      if (load_ok) count_d = load_val;
      else         load_err_d = 1'b1;
    end else if (dec) begin
      if (at_zero) begin
        if (WRAP) begin
          count_d   = count_dec;
          wrapped_d = 1'b1;
        end
      end else begin
        count_d = count_dec;
        done_d  = (count_dec == '0);
      end
    end
    zero_d = (count_d == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q    <= '0;
      zero_q     <= 1'b1;
      done_q     <= 1'b0;
      wrapped_q  <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      zero_q     <= zero_d;
      done_q     <= done_d;
      wrapped_q  <= wrapped_d;
      load_err_q <= load_err_d;
    end
  end

  assign count    = count_q;
  assign zero     = zero_q;
  assign done     = done_q;
  assign wrapped  = wrapped_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_down_counter.sv
module tb_bcd_down_counter;

  typedef struct packed {
    logic        ld;
    logic [11:0] lv;
    logic        dc;
  } stim_t;

  logic        clk;
  logic        reset;
  logic        load;
  logic [11:0] load_val;
  logic        dec;
  logic [11:0] count0, count1;
  logic        zero0, zero1, done0, done1, wrapped0, wrapped1, err0, err1;

  int checks = 0;
  int errors = 0;
  int m0, m1;
  logic [31:0] sb [$];

  localparam logic [31:0] RST_EXP = {12'h000, 4'b1000, 12'h000, 4'b1000};

  bcd_down_counter #(.DIGITS(3), .WRAP(1'b0)) u_sat (
    .clk(clk), .reset(reset), .load(load), .load_val(load_val), .dec(dec),
    .count(count0), .zero(zero0), .done(done0), .wrapped(wrapped0), .load_err(err0)
  );

  bcd_down_counter #(.DIGITS(3), .WRAP(1'b1)) u_wrap (
    .clk(clk), .reset(reset), .load(load), .load_val(load_val), .dec(dec),
    .count(count1), .zero(zero1), .done(done1), .wrapped(wrapped1), .load_err(err1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [31:0] obs();
    return {count0, zero0, done0, wrapped0, err0, count1, zero1, done1, wrapped1, err1};
  endfunction

  // Decimal reference model for one counter instance.
  task automatic model_step(input bit wrap, inout int v, input logic ld,
                            input logic [11:0] lv, input logic dc,
                            output logic [15:0] e);
    logic d, w, er;
    bit legal;
    d = 1'b0; w = 1'b0; er = 1'b0; legal = 1'b1;
    for (int i = 0; i < 3; i++) if (lv[4*i +: 4] > 4'd9) legal = 1'b0;
    if (ld) begin
      if (legal) v = int'(lv[11:8]) * 100 + int'(lv[7:4]) * 10 + int'(lv[3:0]);
      else er = 1'b1;
    end else if (dc) begin
      if (v == 0) begin
        if (wrap) begin v = 999; w = 1'b1; end
      end else begin
        v = v - 1;
        d = (v == 0);
      end
    end
    e = {to_bcd(v), (v == 0), d, w, er};
  endtask

  task automatic cycle(input logic ld, input logic [11:0] lv, input logic dc);
    logic [15:0] e0, e1;
    @(negedge clk);
    load = ld; load_val = lv; dec = dc;
    model_step(1'b0, m0, ld, lv, dc, e0);
    model_step(1'b1, m1, ld, lv, dc, e1);
    sb.push_back({e0, e1});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] e, o;
    o = obs();
    checks++;
    if (o !== RST_EXP) begin
      errors++;
      $display("FAIL reset_initial: got %h expected %h", o, RST_EXP);
    end
    @(negedge clk);
    reset = 1'b0;
    cycle(1'b1, 12'h042, 1'b0);
    e = sb.pop_front(); o = obs(); checks++;
    if (o !== e) begin errors++; $display("FAIL reset_load042: got %h expected %h", o, e); end
    #2 reset = 1'b1;
    #1 o = obs(); checks++;
    if (o !== RST_EXP) begin errors++; $display("FAIL reset_async_042: got %h expected %h", o, RST_EXP); end
    m0 = 0; m1 = 0;
    @(negedge clk);
    reset = 1'b0;
    cycle(1'b1, 12'h001, 1'b0);
    e = sb.pop_front();
    cycle(1'b0, 12'h000, 1'b1);
    e = sb.pop_front(); o = obs(); checks++;
    if (o !== e) begin errors++; $display("FAIL reset_pre_done: got %h expected %h", o, e); end
    #2 reset = 1'b1;
    #1 o = obs(); checks++;
    if (o !== RST_EXP) begin errors++; $display("FAIL reset_async_done: got %h expected %h", o, RST_EXP); end
    m0 = 0; m1 = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_borrow();
    stim_t tbl [7] = '{'{1'b1, 12'h100, 1'b0}, '{1'b0, 12'h000, 1'b1},
                       '{1'b1, 12'h010, 1'b0}, '{1'b0, 12'h000, 1'b1},
                       '{1'b1, 12'h001, 1'b0}, '{1'b0, 12'h000, 1'b1},
                       '{1'b0, 12'h000, 1'b0}};
    logic [31:0] e, o;
    for (int i = 0; i < 7; i++) begin
      cycle(tbl[i].ld, tbl[i].lv, tbl[i].dc);
      e = sb.pop_front(); o = obs(); checks++;
      if (o !== e) begin errors++; $display("FAIL borrow step %0d: got %h expected %h", i, o, e); end
    end
  endtask

  task automatic test_zero_dec();
    stim_t tbl [4] = '{'{1'b1, 12'h000, 1'b0}, '{1'b0, 12'h000, 1'b1},
                       '{1'b0, 12'h000, 1'b1}, '{1'b0, 12'h000, 1'b0}};
    logic [31:0] e, o;
    for (int i = 0; i < 4; i++) begin
      cycle(tbl[i].ld, tbl[i].lv, tbl[i].dc);
      e = sb.pop_front(); o = obs(); checks++;
      if (o !== e) begin errors++; $display("FAIL zero_dec step %0d: got %h expected %h", i, o, e); end
    end
  endtask

  task automatic test_illegal();
    stim_t tbl [8] = '{'{1'b1, 12'h257, 1'b0}, '{1'b1, 12'h1A3, 1'b0},
                       '{1'b0, 12'h000, 1'b0}, '{1'b1, 12'h1A3, 1'b1},
                       '{1'b1, 12'hF00, 1'b0}, '{1'b1, 12'h0A0, 1'b1},
                       '{1'b1, 12'h999, 1'b0}, '{1'b0, 12'h000, 1'b0}};
    logic [31:0] e, o;
    for (int i = 0; i < 8; i++) begin
      cycle(tbl[i].ld, tbl[i].lv, tbl[i].dc);
      e = sb.pop_front(); o = obs(); checks++;
      if (o !== e) begin errors++; $display("FAIL illegal step %0d: got %h expected %h", i, o, e); end
    end
  endtask

  task automatic test_priority();
    stim_t tbl [6] = '{'{1'b1, 12'h050, 1'b1}, '{1'b0, 12'h000, 1'b1},
                       '{1'b1, 12'h005, 1'b0}, '{1'b1, 12'h000, 1'b1},
                       '{1'b0, 12'h000, 1'b0}, '{1'b1, 12'h000, 1'b0}};
    logic [31:0] e, o;
    for (int i = 0; i < 6; i++) begin
      cycle(tbl[i].ld, tbl[i].lv, tbl[i].dc);
      e = sb.pop_front(); o = obs(); checks++;
      if (o !== e) begin errors++; $display("FAIL priority step %0d: got %h expected %h", i, o, e); end
    end
  endtask

  task automatic test_back_to_back();
    stim_t tbl [6] = '{'{1'b1, 12'h003, 1'b0}, '{1'b0, 12'h000, 1'b1},
                       '{1'b0, 12'h000, 1'b1}, '{1'b0, 12'h000, 1'b1},
                       '{1'b0, 12'h000, 1'b1}, '{1'b0, 12'h000, 1'b0}};
    logic [31:0] e, o;
    for (int i = 0; i < 6; i++) begin
      cycle(tbl[i].ld, tbl[i].lv, tbl[i].dc);
      e = sb.pop_front(); o = obs(); checks++;
      if (o !== e) begin errors++; $display("FAIL back_to_back step %0d: got %h expected %h", i, o, e); end
    end
  endtask

  task automatic test_sweep();
    logic [31:0] e, o;
    int done_hits, done_at;
    done_hits = 0; done_at = -1;
    cycle(1'b1, 12'h999, 1'b0);
    e = sb.pop_front(); o = obs(); checks++;
    if (o !== e) begin errors++; $display("FAIL sweep_load: got %h expected %h", o, e); end
    for (int k = 1; k <= 1002; k++) begin
      cycle(1'b0, 12'h000, 1'b1);
      e = sb.pop_front(); o = obs(); checks++;
      if (o !== e) begin errors++; $display("FAIL sweep cycle %0d: got %h expected %h", k, o, e); end
      if (done0 === 1'b1) begin done_hits++; done_at = k; end
    end
    checks++;
    if (done_hits != 1 || done_at != 999) begin
      errors++;
      $display("FAIL sweep_done: got %0d pulses last at %0d, expected 1 pulse at 999", done_hits, done_at);
    end
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; load_val = 12'h000; dec = 1'b0;
    m0 = 0; m1 = 0;
    #12;
    test_reset();
    test_borrow();
    test_zero_dec();
    test_illegal();
    test_priority();
    test_back_to_back();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
